// File: rtl/mux_arbiter.sv
// Round-robin N:1 arbiter feeding one registered WIDTH-bit output stage through a shared mux.
// Define MUX_ARBITER_PACKET_LOCK_EN to keep the grant on one requester until its in_last beat.
module mux_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    input  logic               out_ready
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]    ptr_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_last_r;

    logic [N-1:0]     elig_s;
    logic [PW-1:0]    win_s;
    logic [PW-1:0]    next_ptr_s;
    logic             load_s;
    logic [WIDTH-1:0] mux_data_s;
    logic             mux_last_s;

    function automatic logic [N-1:0] onehot(input logic [PW-1:0] idx);
        onehot = {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

    // First eligible index at or after start, wrapping modulo N.
    function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] req, input logic [PW-1:0] start);
        logic [PW-1:0] pick;
        logic          hit;
        int            idx;
        pick = start;
        hit  = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(start) + k;
            if (idx >= N) begin
                idx = idx - N;
            end else begin
                idx = idx;
            end
            if (!hit && req[PW'(idx)]) begin
                pick = PW'(idx);
                hit  = 1'b1;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

`ifdef MUX_ARBITER_PACKET_LOCK_EN
    logic          lock_r;
    logic [PW-1:0] lock_id_r;

    // While a packet is open only its owner is eligible.
    always_comb begin
        if (lock_r) begin
            elig_s = in_valid & onehot(lock_id_r);
        end else begin
            elig_s = in_valid;
        end
    end
`else
    // Per-beat arbitration: every valid requester is eligible.
    always_comb begin
        elig_s = in_valid;
    end
`endif

    // Winner selection, shared data mux and load decision.
    always_comb begin
        win_s      = rr_pick(elig_s, ptr_r);
        mux_data_s = in_data[win_s*WIDTH +: WIDTH];
        mux_last_s = in_last[win_s];
        load_s     = !rst && (!out_valid_r || out_ready) && (|elig_s);
        if (win_s == PW'(N-1)) begin
            next_ptr_s = {PW{1'b0}};
        end else begin
            next_ptr_s = win_s + PW'(1);
        end
    end

    // Accept strobe goes only to the winner, and only when it loads.
    always_comb begin
        if (load_s) begin
            in_ready = onehot(win_s);
        end else begin
            in_ready = {N{1'b0}};
        end
    end

    // Output register, pointer and lock state.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_last_r  <= 1'b0;
            ptr_r       <= {PW{1'b0}};
`ifdef MUX_ARBITER_PACKET_LOCK_EN
            lock_r      <= 1'b0;
            lock_id_r   <= {PW{1'b0}};
`endif
        end else begin
            if (load_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= mux_data_s;
                out_last_r  <= mux_last_s;
`ifdef MUX_ARBITER_PACKET_LOCK_EN
                if (mux_last_s) begin
                    lock_r <= 1'b0;
                    ptr_r  <= next_ptr_s;
                end else begin
                    lock_r    <= 1'b1;
                    lock_id_r <= win_s;
                end
`else
                ptr_r <= next_ptr_s;
`endif
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: stimulus pushes expected beats, a negedge monitor pops and compares.
// Scenarios follow MUX_ARBITER_PACKET_LOCK_EN when it is defined for the build.
module tb_mux_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_last = '0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready = 1'b0;

    int vecs = 0;
    int errs = 0;
    logic [W:0]   q[$];
    logic [W-1:0] got[$];
    logic [W:0]   mon_exp;
    int m_ptr = 0;
    bit m_lock = 1'b0;
    int m_lock_id = 0;
    int n_in = 0;
    int n_out = 0;
    int waitc[N];
    int max_wait = 0;

    always #5 clk = ~clk;

    mux_arbiter #(.N(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare the accepted-beat log against a hand-written sequence (first beat in the low byte).
    task automatic chk_seq(input string name, input int n, input logic [63:0] exp);
        logic [63:0] act;
        act = '0;
        chk({name, "_len"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < got.size() && i < 8; i++) act[i*8 +: 8] = got[i];
        chk(name, act, exp);
    endtask

    // One clock of stimulus; the reference model predicts the grant and pushes the loaded beat.
    task automatic cyc(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic [N-1:0] l, input logic r);
        logic [N-1:0] elig;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] one;
        int  win;
        bit  any_req;
        bit  load;
        bit  decision;
        in_valid = v; in_data = d; in_last = l; out_ready = r;
        #2;
        one  = 1;
        elig = v;
`ifdef MUX_ARBITER_PACKET_LOCK_EN
        if (m_lock) elig = v & (one << m_lock_id);
`endif
        any_req = (elig != 0);
        win = 0;
        for (int k = N - 1; k >= 0; k--) if (elig[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        load = any_req && ((q.size() == 0) || r);
        exp_rdy = load ? (one << win) : '0;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        decision = 1'b1;
        if (load) begin
            q.push_back({d[win*W +: W], l[win]});
            n_in++;
`ifdef MUX_ARBITER_PACKET_LOCK_EN
            decision = l[win];
            if (l[win]) begin
                m_lock = 1'b0;
                m_ptr  = (win + 1) % N;
            end else begin
                m_lock    = 1'b1;
                m_lock_id = win;
            end
`else
            m_ptr = (win + 1) % N;
`endif
        end
        for (int j = 0; j < N; j++) begin
            if (!v[j] || (load && j == win)) waitc[j] = 0;
            else if (load && decision) waitc[j]++;
            if (waitc[j] > max_wait) max_wait = waitc[j];
        end
        #1;
    endtask

    task automatic do_reset(input logic [N-1:0] v);
        rst = 1'b1; in_valid = v; out_ready = 1'b0;
        #2;
        chk("in_ready_rst", 64'(in_ready), 64'd0);
        @(posedge clk);
        q.delete();
        m_ptr = 0; m_lock = 1'b0; m_lock_id = 0;
        for (int j = 0; j < N; j++) waitc[j] = 0;
        #1;
        rst = 1'b0;
    endtask

    // Monitor: out_valid must track the scoreboard; each handshake retires the oldest expected beat.
    always @(negedge clk) begin
        if (!rst) begin
            vecs++;
            if (out_valid !== (q.size() != 0)) begin
                errs++;
                $display("FAIL out_valid: got %b expected %b", out_valid, (q.size() != 0));
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL extra_beat: got %h expected none", out_data);
                end else begin
                    mon_exp = q.pop_front();
                    vecs++;
                    if ({out_data, out_last} !== mon_exp) begin
                        errs++;
                        $display("FAIL beat: got %h/%b expected %h/%b", out_data, out_last, mon_exp[W:1], mon_exp[0]);
                    end
                end
                got.push_back(out_data);
                n_out++;
            end
        end
    end

    initial begin
        for (int j = 0; j < N; j++) waitc[j] = 0;

        // Reset state, then all four requesters with out_ready held high.
        do_reset(4'b0000);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        got.delete();
        cyc(4'b1111, 32'h13121110, 4'b1111, 1'b1);
        chk("s1_first_valid", 64'(out_valid), 64'd1);
        chk("s1_first_data", 64'(out_data), 64'h10);
        repeat (4) cyc(4'b1111, 32'h13121110, 4'b1111, 1'b1);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b1);
        chk_seq("s1_seq", 5, 64'h10_13_12_11_10);

        // Single requester held off by a 3-cycle stall.
        got.delete();
        cyc(4'b0100, 32'h00A50000, 4'b0100, 1'b0);
        chk("s2_load_valid", 64'(out_valid), 64'd1);
        repeat (3) begin
            cyc(4'b0100, 32'h00A50000, 4'b0100, 1'b0);
            chk("s2_hold_valid", 64'(out_valid), 64'd1);
            chk("s2_hold_data", 64'(out_data), 64'hA5);
            chk("s2_hold_ready", 64'(in_ready), 64'd0);
        end
        cyc(4'b0000, 32'h0, 4'b0000, 1'b1);
        chk("s2_cleared", 64'(out_valid), 64'd0);
        chk_seq("s2_seq", 1, 64'hA5);

        // Requesters 0 and 2 alternate.
        got.delete();
        repeat (4) cyc(4'b0101, 32'h00220020, 4'b0101, 1'b1);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b1);
        chk_seq("s3_alt", 4, 64'h22_20_22_20);

`ifdef MUX_ARBITER_PACKET_LOCK_EN
        // A 3-beat packet from requester 1 is not interleaved with requester 3.
        do_reset(4'b0000);
        got.delete();
        cyc(4'b1010, 32'h3F003100, 4'b1000, 1'b1);
        cyc(4'b1010, 32'h3F003200, 4'b1000, 1'b1);
        cyc(4'b1010, 32'h3F003300, 4'b1010, 1'b1);
        cyc(4'b1000, 32'h3F000000, 4'b1000, 1'b1);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b1);
        chk_seq("s4_packet", 4, 64'h3F_33_32_31);
`endif

        // Reset while a beat is held (and the lock is open when enabled).
        got.delete();
        cyc(4'b0001, 32'h00000050, 4'b0000, 1'b0);
        cyc(4'b0001, 32'h00000050, 4'b0000, 1'b0);
        chk("s5_held", 64'(out_valid), 64'd1);
        do_reset(4'b1010);
        chk("s5_rst_valid", 64'(out_valid), 64'd0);
        cyc(4'b1010, 32'h43004100, 4'b1010, 1'b1);
        chk("s5_first_grant", 64'(out_data), 64'h41);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b1);
        chk_seq("s5_seq", 1, 64'h41);

        // Random traffic against the reference model.
        do_reset(4'b0000);
        got.delete();
        n_in = 0; n_out = 0; max_wait = 0;
        repeat (10000) cyc(N'($urandom), (N*W)'($urandom), N'($urandom), 1'($urandom_range(0, 1)));
        repeat (3) cyc(4'b0000, 32'h0, 4'b0000, 1'b1);
        chk("rand_no_loss", 64'(n_out), 64'(n_in));
        chk("rand_drained", 64'(q.size()), 64'd0);
        chk("rand_fairness", 64'(max_wait > N), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
